// File: rtl/float_fixed_pkg.sv
// rtl/float_fixed_pkg.sv - shared types and constants for the float-to-fixed converter
package float_fixed_pkg;
    localparam int FLOAT_BIAS = 127;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;
    localparam int FIXED_W    = 16;

    localparam logic [FIXED_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [FIXED_W-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

    typedef struct packed {
        logic               sign;
        logic [FIXED_W-1:0] int_mag;
        logic               rnd;
        logic               sticky;
        logic               ovf;
        logic               nan;
        logic               zero;
    } s1_pay_t;
endpackage

// File: rtl/float_unpack.sv
// rtl/float_unpack.sv - classify a single-precision value and align its significand
module float_unpack
    import float_fixed_pkg::*;
#(
    parameter int FRAC_BITS = 0
) (
    input  float_t   i_float,
    output s1_pay_t  o_pay
);

    logic signed [9:0] sh;
    logic [4:0]        rs;
    logic [23:0]       sig;
    logic [23:0]       mask;

    always_comb begin
        o_pay      = '0;
        o_pay.sign = i_float.sign;
        sig        = {1'b1, i_float.mant};
        sh         = {2'b00, i_float.exp} - 10'(FLOAT_BIAS) + 10'(FRAC_BITS);
        // sh in -1..14 maps to a right shift of 9..24, which fits in 5 bits
        rs         = 5'd23 - sh[4:0];
        mask       = (24'd1 << (rs - 5'd1)) - 24'd1;

        if (i_float.exp == 8'hFF) begin
            if (i_float.mant != '0) o_pay.nan = 1'b1;
            else                    o_pay.ovf = 1'b1;
        end else if (i_float.exp == 8'h00) begin
            o_pay.zero   = 1'b1;
            o_pay.sticky = (i_float.mant != '0);
        end else if (sh >= 10'sd16) begin
            o_pay.ovf = 1'b1;
        end else if (sh == 10'sd15) begin
            // -2^15 is the only representable value at this exponent
            if (i_float.sign && i_float.mant == '0) o_pay.int_mag = SAT_NEG;
            else                                    o_pay.ovf     = 1'b1;
        end else if (sh < -10'sd1) begin
            o_pay.sticky = 1'b1;
        end else begin
            o_pay.int_mag = 16'(sig >> rs);
            o_pay.rnd     = sig[rs - 5'd1];
            o_pay.sticky  = |(sig & mask);
        end
    end

endmodule

// File: rtl/float_to_fixed.sv
// rtl/float_to_fixed.sv - two-stage IEEE-754 single to 16-bit fixed converter, RNE and saturating
module float_to_fixed
    import float_fixed_pkg::*;
#(
    parameter int FRAC_BITS = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_float,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [FIXED_W-1:0] o_fixed,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_overflow,
    output logic               o_nan,
    output logic               o_inexact
);

    float_t   in_f;
    s1_pay_t  unpack_pay;
    s1_pay_t  s1_pay_d, s1_pay_q;
    logic     s1_valid_d, s1_valid_q;
    logic     out_valid_d, out_valid_q;
    logic [FIXED_W-1:0] fixed_d, fixed_q;
    logic     ovf_d, ovf_q, nan_d, nan_q, inex_d, inex_q;

    logic     s1_adv, s2_adv;
    logic [FIXED_W:0]   mag;
    logic [FIXED_W-1:0] res_fixed;
    logic     res_ovf, res_nan, res_inex;

    assign in_f = i_float;

    float_unpack #(.FRAC_BITS(FRAC_BITS)) u_unpack (
        .i_float (in_f),
        .o_pay   (unpack_pay)
    );

    always_comb begin
        mag = {1'b0, s1_pay_q.int_mag}
            + 17'(s1_pay_q.rnd & (s1_pay_q.sticky | s1_pay_q.int_mag[0]));
        res_fixed = '0;
        res_ovf   = 1'b0;
        res_nan   = 1'b0;
        res_inex  = 1'b0;
        if (s1_pay_q.nan) begin
            res_nan = 1'b1;
        end else if (s1_pay_q.ovf) begin
            res_ovf   = 1'b1;
            res_fixed = s1_pay_q.sign ? SAT_NEG : SAT_POS;
        end else if (s1_pay_q.zero) begin
            res_inex = s1_pay_q.sticky;
        end else if (!s1_pay_q.sign && mag > 17'd32767) begin
            res_ovf   = 1'b1;
            res_fixed = SAT_POS;
        end else if (s1_pay_q.sign && mag > 17'd32768) begin
            res_ovf   = 1'b1;
            res_fixed = SAT_NEG;
        end else begin
            res_inex  = s1_pay_q.rnd | s1_pay_q.sticky;
            res_fixed = s1_pay_q.sign ? (~mag[FIXED_W-1:0] + 16'd1) : mag[FIXED_W-1:0];
        end
    end

    always_comb begin
        s2_adv  = !out_valid_q || i_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        o_ready = s1_adv;

        s1_valid_d  = s1_adv ? i_valid : s1_valid_q;
        s1_pay_d    = (s1_adv && i_valid) ? unpack_pay : s1_pay_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

        fixed_d = fixed_q;
        ovf_d   = ovf_q;
        nan_d   = nan_q;
        inex_d  = inex_q;
        if (s2_adv && s1_valid_q) begin
            fixed_d = res_fixed;
            ovf_d   = res_ovf;
            nan_d   = res_nan;
            inex_d  = res_inex;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s1_pay_q    <= '0;
            out_valid_q <= 1'b0;
            fixed_q     <= '0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            inex_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pay_q    <= s1_pay_d;
            out_valid_q <= out_valid_d;
            fixed_q     <= fixed_d;
            ovf_q       <= ovf_d;
            nan_q       <= nan_d;
            inex_q      <= inex_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_fixed    = fixed_q;
    assign o_overflow = ovf_q;
    assign o_nan      = nan_q;
    assign o_inexact  = inex_q;

endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Converts IEEE-754 single-precision values to 16-bit signed two's-complement fixed point. This is the inverse of the existing fixed-to-float path.
- Sits on the filter datapath return side and feeds float coefficient/sample results back into fixed-point filter stages.
- Two-stage pipeline, valid/ready on both sides, one result per cycle when not stalled.
- Round-to-nearest-even, saturating, with per-result status flags.

Parameters:
- FRAC_BITS, 0: number of fractional bits in the output. Output = round(x * 2^FRAC_BITS). Legal range 0..14; 0 gives a plain integer.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_float  in  32  IEEE-754 single input {sign, exp[7:0], mant[22:0]}.
- i_valid  in  1  i_float is valid.
- o_ready  out  1  block accepts i_float this cycle.
- o_fixed  out  16  signed fixed-point result.
- o_valid  out  1  o_fixed and the flags are valid.
- i_ready  in  1  downstream accepts the result.
- o_overflow  out  1  result was saturated (|x| too large, or Inf).
- o_nan  out  1  input was NaN; o_fixed = 0.
- o_inexact  out  1  nonzero bits were discarded by rounding.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - Both stage valids clear; o_valid=0; o_fixed=0; all flags 0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-operation discards in-flight data; no partial result is ever emitted.
- Handshake:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - o_valid, o_fixed and the flags hold stable while o_valid & ~i_ready.
  - o_valid never drops without a transfer.
- Pipeline control:
  - s2_adv = ~o_valid | i_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - o_ready = s1_adv (combinational from i_ready; no combinational path from i_valid to o_ready).
- Latency and throughput: 2 cycles from input transfer to o_valid with no stall; full throughput, 1 per cycle.
- Stage 1 (unpack/align):
  - sh = exp - 127 + FRAC_BITS, a 10-bit signed value.
  - exp==0 (zero or denormal): magnitude 0. inexact = (mant!=0).
  - exp==255, mant!=0: NaN. exp==255, mant==0: Inf, treated as overflow.
  - sh >= 16: overflow.
  - sh == 15: overflow, except sign=1 & mant==0, which gives exactly -32768.
  - sh <= -2: magnitude 0; round=0; sticky=1.
  - Otherwise, with sig = {1, mant} (24 bits):
    - int = sig >> (23 - sh), 16 bits.
    - round bit = bit (22 - sh) of sig.
    - sticky = OR of the bits below the round bit.
    - For sh = -1: int = 0 and round = sig[23].
- Stage 2 (round/saturate/negate):
  - mag = int + (round & (sticky | int[0])), 17 bits.
  - inexact = round | sticky.
  - Positive: mag > 32767 -> saturate to 0x7FFF, o_overflow=1.
  - Negative: mag > 32768 -> saturate to 0x8000, o_overflow=1. Otherwise o_fixed = -mag.
  - Overflow and Inf saturate by sign: 0x7FFF or 0x8000.
  - NaN: o_fixed = 0x0000, o_nan=1, o_overflow=0, o_inexact=0.
  - On overflow, o_inexact=0.
- Signed zero: -0.0 -> 0x0000, no flags.
- Simultaneous input and output transfers in the same cycle are legal and lose no data.

Decomposition:
- Package float_fixed_pkg holds:
  - FLOAT_BIAS = 127, EXP_W = 8, MANT_W = 23, FIXED_W = 16.
  - typedef struct packed float_t {sign, exp, mant}.
  - typedef struct for the stage-1 to stage-2 payload: sign, int, round, sticky, ovf, nan, zero.
- One sub-module, float_unpack: combinational classify and align for stage 1. Rounding and pipeline control stay in float_to_fixed.

Test Plan:
- Basic values (FRAC_BITS=0), expected o_fixed and flags:
  - 0x3F800000 (1.0) -> 0x0001, no flags.
  - 0xBF800000 (-1.0) -> 0xFFFF.
  - 0x00000000 -> 0x0000.
  - 0x80000000 -> 0x0000.
  - o_valid asserts 2 cycles after each input transfer.
- Rounding ties to even:
  - 0x40200000 (2.5) -> 0x0002, inexact.
  - 0x40600000 (3.5) -> 0x0004, inexact.
  - 0x3F000000 (0.5) -> 0x0000, inexact.
  - 0xBFC00000 (-1.5) -> 0xFFFE, inexact.
- Saturation:
  - 0x471C4000 (40000.0) -> 0x7FFF, overflow.
  - 0xC7000000 (-32768.0) -> 0x8000, no flags.
  - 0x46FFFF00 (32767.5) -> 0x7FFF, overflow.
  - 0x7F800000 (+Inf) -> 0x7FFF, overflow.
  - 0x7FC00000 (NaN) -> 0x0000, nan.
- FRAC_BITS=8:
  - 0x3FC00000 (1.5) -> 0x0180.
  - 0x3B800000 (2^-8) -> 0x0001.
- Backpressure:
  - Stream 6 back-to-back inputs with i_ready toggling 1,0,0,1,...
  - Required: outputs in order with none lost or duplicated; o_fixed stable while stalled; o_ready=0 only when both stages are full and i_ready=0.
- Reset mid-stream: assert i_rst with both stages full -> next cycle o_valid=0, o_ready=1; the first input after reset appears 2 cycles later with the correct value.
